// File: rtl/rsa_asip_pkg.sv
// Shared RSA ASIP types and memory-map constants.
// Used by the inbound loader and the system control logic.
package rsa_asip_pkg;

    localparam int MEM_ADDR_W = 18;

    localparam logic [MEM_ADDR_W-1:0] IO_SELECT_ADDR = 18'h3D08D;
    localparam logic [MEM_ADDR_W-1:0] IO_SECTOR_ADDR = 18'h3D08E;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        WRITE,
        ACK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk. No backpressure; output simply follows input.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_input_loader.sv
// Inbound GPIO DMA: 4-phase strobe/ack byte source -> sequential data-memory writes.
// Latency: strobe pin high at edge k -> m_wren during k+2..k+3 -> gpio_ack at k+3.
// Backpressure: the source is paced by gpio_ack; the next byte is taken only after strobe falls.
module gpio_input_loader
    import rsa_asip_pkg::*;
#(
    parameter int                ADDR_W    = MEM_ADDR_W,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_BYTES = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              gpio_strobe,
    output logic              gpio_ack,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W-1:0] NUM_C = ADDR_W'(NUM_BYTES);

    // count never wraps and the load must stay clear of the switch-mapped IO window.
    if (NUM_BYTES < 1 || 64'(NUM_BYTES) > ((64'd1 << ADDR_W) - 64'd1)) begin : g_bad_num
        $error("gpio_input_loader: NUM_BYTES out of range for ADDR_W");
    end
    if ((64'(BASE_ADDR) + 64'(NUM_BYTES)) > 64'(IO_SELECT_ADDR)) begin : g_bad_map
        $error("gpio_input_loader: load region reaches IO_SELECT_ADDR");
    end

    logic strobe_s;
    logic start_q;
    logic start_rise;

    loader_state_t     state_q,    state_d;
    logic [ADDR_W-1:0] count_q,    count_d;
    logic [15:0]       checksum_q, checksum_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              wren_q,     wren_d;
    logic              ack_q,      ack_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    sync_2ff #(.W(1)) u_strobe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_strobe),
        .q_o   (strobe_s)
    );

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = 1'b0;
        ack_d      = ack_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d    = WAIT_REQ;
                    count_d    = '0;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            WAIT_REQ: begin
                // gpio_in is safe to sample here: the source holds it from before strobe rise.
                if (strobe_s) begin
                    state_d = WRITE;
                    wdata_d = gpio_in;
                    addr_d  = BASE_ADDR + count_q;
                    wren_d  = 1'b1;
                end
            end
            WRITE: begin
                state_d    = ACK;
                count_d    = count_q + 1'b1;
                checksum_d = checksum_q + 16'(wdata_q);
                ack_d      = 1'b1;
            end
            ACK: begin
                if (!strobe_s) begin
                    ack_d = 1'b0;
                    if (count_q == NUM_C) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            count_q    <= '0;
            checksum_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Registered outputs: wren_q is high exactly while state_q == WRITE, address already stable.
    assign gpio_ack  = ack_q;
    assign m_address = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wren    = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_gpio_input_loader.sv
// Directed bench for gpio_input_loader with a 4-byte load at base 0x100.
module tb_gpio_input_loader;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          gpio_strobe;
    logic [7:0]    gpio_in;
    logic          gpio_ack;
    logic [AW-1:0] m_address;
    logic [7:0]    m_wdata;
    logic          m_wren;
    logic          busy;
    logic          done;
    logic [AW-1:0] count;
    logic [15:0]   checksum;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wr_addr [$];
    logic [7:0]    wr_data [$];

    logic [7:0]    exp_b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

    always #5 clk = ~clk;

    gpio_input_loader #(
        .ADDR_W    (18),
        .DATA_W    (8),
        .BASE_ADDR (18'h100),
        .NUM_BYTES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .gpio_in     (gpio_in),
        .gpio_strobe (gpio_strobe),
        .gpio_ack    (gpio_ack),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_wren      (m_wren),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .checksum    (checksum)
    );

    // RAM model: captures on the falling edge, like the real memory.
    always @(negedge clk) begin
        if (m_wren === 1'b1) begin
            wr_addr.push_back(m_address);
            wr_data.push_back(m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (gpio_ack !== lvl && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(gpio_ack), 32'(lvl));
    endtask

    task automatic send_byte(input logic [7:0] b);
        gpio_in     = b;
        gpio_strobe = 1'b1;
        wait_ack(1'b1, "ack_rise");
        gpio_strobe = 1'b0;
        wait_ack(1'b0, "ack_fall");
        gpio_in = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b1;
        gpio_strobe = 1'b1;
        gpio_in     = 8'h5A;
        repeat (3) tick();
        check("rst_ack",      32'(gpio_ack),  32'h0);
        check("rst_wren",     32'(m_wren),    32'h0);
        check("rst_busy",     32'(busy),      32'h0);
        check("rst_done",     32'(done),      32'h0);
        check("rst_count",    32'(count),     32'h0);
        check("rst_checksum", 32'(checksum),  32'h0);
        check("rst_addr",     32'(m_address), 32'h0);
        check("rst_wdata",    32'(m_wdata),   32'h0);
        check("rst_nowrite",  32'(wr_addr.size()), 32'h0);
        start       = 1'b0;
        gpio_strobe = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_busy", 32'(busy),     32'h0);
        check("idle_ack",  32'(gpio_ack), 32'h0);

        // First byte with exact latency checks
        pulse_start();
        check("start_busy", 32'(busy), 32'h1);
        gpio_in     = 8'hA5;
        gpio_strobe = 1'b1;
        tick();
        check("lat_k_wren",  32'(m_wren), 32'h0);
        tick();
        check("lat_k1_wren", 32'(m_wren), 32'h0);
        tick();
        check("lat_k2_wren",  32'(m_wren),    32'h1);
        check("lat_k2_addr",  32'(m_address), 32'h100);
        check("lat_k2_wdata", 32'(m_wdata),   32'hA5);
        check("lat_k2_ack",   32'(gpio_ack),  32'h0);
        tick();
        check("lat_k3_wren", 32'(m_wren),   32'h0);
        check("lat_k3_ack",  32'(gpio_ack), 32'h1);
        gpio_strobe = 1'b0;
        wait_ack(1'b0, "b0_ack_fall");
        check("b0_count",    32'(count),    32'h1);
        check("b0_checksum", 32'(checksum), 32'hA5);

        // Second byte: strobe held long
        gpio_in     = 8'h3C;
        gpio_strobe = 1'b1;
        wait_ack(1'b1, "hold_ack_rise");
        repeat (20) tick();
        check("hold_ack_high", 32'(gpio_ack),       32'h1);
        check("hold_writes",   32'(wr_addr.size()), 32'h2);
        gpio_strobe = 1'b0;
        tick();
        tick();
        check("hold_ack_2clk", 32'(gpio_ack), 32'h1);
        tick();
        check("hold_ack_3clk", 32'(gpio_ack), 32'h0);

        send_byte(8'hFF);
        send_byte(8'h01);
        check("fin_done",     32'(done),      32'h1);
        check("fin_busy",     32'(busy),      32'h0);
        check("fin_count",    32'(count),     32'h4);
        check("fin_checksum", 32'(checksum),  32'h01E1);
        check("fin_addr",     32'(m_address), 32'h103);
        check("fin_wdata",    32'(m_wdata),   32'h01);
        check("fin_writes",   32'(wr_addr.size()), 32'h4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr%0d_addr", i), 32'(wr_addr[i]), 32'h100 + 32'(i));
            check($sformatf("wr%0d_data", i), 32'(wr_data[i]), 32'(exp_b[i]));
        end

        // Strobes ignored in DONE
        for (int i = 0; i < 2; i++) begin
            gpio_strobe = 1'b1;
            repeat (5) tick();
            gpio_strobe = 1'b0;
            repeat (5) tick();
        end
        check("done_ign_writes", 32'(wr_addr.size()), 32'h4);
        check("done_ign_ack",    32'(gpio_ack),       32'h0);
        check("done_ign_done",   32'(done),           32'h1);

        // Reload from DONE
        pulse_start();
        tick();
        check("reload_count",    32'(count),    32'h0);
        check("reload_checksum", 32'(checksum), 32'h0);
        check("reload_done",     32'(done),     32'h0);
        check("reload_busy",     32'(busy),     32'h1);
        send_byte(8'h77);
        check("reload_addr",  32'(wr_addr[4]), 32'h100);
        check("reload_data",  32'(wr_data[4]), 32'h77);
        check("reload_count1", 32'(count),     32'h1);

        // Reset pulse during ACK of byte 2
        gpio_in     = 8'h12;
        gpio_strobe = 1'b1;
        wait_ack(1'b1, "abort_ack_rise");
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ack_async", 32'(gpio_ack), 32'h0);
        check("abort_busy",      32'(busy),     32'h0);
        check("abort_wren",      32'(m_wren),   32'h0);
        tick();
        tick();
        gpio_strobe = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_writes", 32'(wr_addr.size()), 32'h6);
        check("abort_idle",   32'(busy),           32'h0);
        check("abort_count",  32'(count),          32'h0);

        pulse_start();
        send_byte(8'h9C);
        check("restart_writes",   32'(wr_addr.size()), 32'h7);
        check("restart_addr",     32'(wr_addr[6]),     32'h100);
        check("restart_data",     32'(wr_data[6]),     32'h9C);
        check("restart_count",    32'(count),          32'h1);
        check("restart_checksum", 32'(checksum),       32'h9C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
